// File: rtl/spi_txn_ctrl.sv
// -----------------------------------------------------------------------------
// spi_txn_ctrl
//
// Multi-byte transaction controller that sits in front of a byte-level SPI
// master. It accepts a request of 1..MAX_BYTES bytes and feeds the bytes one at
// a time over the tx_data/tx_valid/tx_done handshake. It collects the MISO
// byte returned for each byte sent, and returns the whole receive buffer on a
// valid/ready response port. Bytes are presented back-to-back so that the
// master keeps chip select asserted for the whole transaction.
//
// Optional feature: define SPI_TXN_TIMEOUT_EN to build a per-byte watchdog
// (TIMEOUT_CYCLES). When it is not defined, SEND waits indefinitely for
// m_tx_done.
//
// Ports
//   clk, rst     : single clock; asynchronous active-high reset
//   req_valid    : request present (sampled only in IDLE)
//   req_ready    : high only in IDLE
//   req_len      : number of bytes to transfer (1..MAX_BYTES; others rejected)
//   req_wdata    : TX bytes, byte i at [8i+7:8i], byte 0 sent first
//   rsp_valid    : response present (RESP state)
//   rsp_ready    : response accepted
//   rsp_len      : bytes actually completed
//   rsp_rdata    : RX bytes, same packing as req_wdata, unused bytes zero
//   rsp_err      : bad length or watchdog expiry
//   m_tx_data    : byte to the SPI master
//   m_tx_valid   : byte pending to the SPI master
//   m_tx_done    : one-cycle pulse, master finished the current byte
//   m_rx_data    : received byte, valid in the m_tx_done cycle
//   busy         : controller not in IDLE
// -----------------------------------------------------------------------------
module spi_txn_ctrl #(
  parameter int MAX_BYTES      = 8,
  parameter int LEN_W          = $clog2(MAX_BYTES + 1),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [8*MAX_BYTES-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [LEN_W-1:0]       rsp_len,
  output logic [8*MAX_BYTES-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [7:0]             m_tx_data,
  output logic                   m_tx_valid,
  input  logic                   m_tx_done,
  input  logic [7:0]             m_rx_data,
  output logic                   busy
);

  localparam int               IDX_W   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [MAX_BYTES-1:0][7:0] tx_buf;
  logic [MAX_BYTES-1:0][7:0] rx_buf;
  logic [LEN_W-1:0]          len;
  logic [IDX_W-1:0]          idx;

  logic accept;
  logic bad_len;
  logic last_byte;
  logic expire;

  assign accept  = (state == IDLE) && req_valid;
  assign bad_len = (req_len == '0) || (req_len > MAX_LEN);

  // Compare at LEN_W bits so a full-length transfer (len == MAX_BYTES) does
  // not wrap the index arithmetic.
  assign last_byte = ((LEN_W'(idx) + LEN_W'(1)) == len);

  assign rsp_rdata = rx_buf;

`ifdef SPI_TXN_TIMEOUT_EN
  localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo;

  // m_tx_done in the expiry cycle takes priority: the byte completes normally.
  assign expire = (state == SEND) && !m_tx_done && (tmo == TMO_LAST);

  // Cleared whenever a byte is first presented; counts SEND cycles waiting
  // for m_tx_done. Expiry leaves SEND, so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo <= '0;
    end else if (accept || ((state == SEND) && m_tx_done)) begin
      tmo <= '0;
    end else if (state == SEND) begin
      tmo <= tmo + 1'b1;
    end
  end
`else
  assign expire = 1'b0;

  // TIMEOUT_CYCLES is kept for drop-in instantiation; no watchdog is built.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = bad_len ? RESP : SEND;
        end
      end
      SEND: begin
        if ((m_tx_done && last_byte) || expire) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready  = 1'b0;
    busy       = 1'b1;
    m_tx_valid = 1'b0;
    m_tx_data  = '0;
    rsp_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      SEND: begin
        m_tx_valid = 1'b1;
        m_tx_data  = tx_buf[idx];
      end
      RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Transaction datapath: request latch, byte index, RX buffer and the
  // response fields, which stay frozen for the whole of RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf  <= '0;
      rx_buf  <= '0;
      len     <= '0;
      idx     <= '0;
      rsp_len <= '0;
      rsp_err <= 1'b0;
    end else if (accept) begin
      tx_buf  <= req_wdata;
      len     <= req_len;
      rx_buf  <= '0;
      idx     <= '0;
      rsp_len <= '0;
      rsp_err <= bad_len;
    end else if (state == SEND) begin
      if (m_tx_done) begin
        rx_buf[idx] <= m_rx_data;
        if (last_byte) begin
          rsp_len <= len;
          rsp_err <= 1'b0;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (expire) begin
        // idx equals the number of bytes already completed.
        rsp_len <= LEN_W'(idx);
        rsp_err <= 1'b1;
      end
    end
  end

endmodule
